// File: rtl/icesid_pkg.sv
// Shared definitions for the icesid datapath blocks: sweep FSM states,
// multiplier pipeline depth and the result width reduction helper.
package icesid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } mdac_state_t;

    localparam int MDAC_PIPE_DEPTH = 3;

    // Clamp to a signed w-bit range when sat is set; otherwise pass the value
    // through so the caller's slice to w bits wraps in two's complement.
    function automatic logic signed [63:0] mdac_reduce(
        input logic signed [63:0] v,
        input int                 w,
        input bit                 sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (sat && (v > hi)) begin
            return hi;
        end
        if (sat && (v < lo)) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mdac_mul.sv
// Registered signed x unsigned multiplier (operands up to 16x16). Written so the
// iCE40 DSP inference maps it onto one SB_MAC16 (A signed, B unsigned, 16x16 out).
module mdac_mul #(
    parameter int A_WIDTH = 12,
    parameter int B_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [A_WIDTH-1:0]        a,
    input  logic        [B_WIDTH-1:0]        b,
    output logic signed [A_WIDTH+B_WIDTH:0]  p
);

    logic signed [A_WIDTH+B_WIDTH:0] a_x;
    logic signed [A_WIDTH+B_WIDTH:0] b_x;

    // The gain is widened with a zero sign bit so the product is a pure signed multiply.
    assign a_x = {{(B_WIDTH+1){a[A_WIDTH-1]}}, a};
    assign b_x = {{(A_WIDTH+1){1'b0}}, b};

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else begin
            p <= a_x * b_x;
        end
    end

endmodule

// File: rtl/mdac_shared.sv
// Time-multiplexed multiplying DAC: one shared multiplier scales CHANNELS samples
// per sweep and commits all results together. MDAC_SATURATE_EN selects clamping.
//
// state | meaning
// IDLE  | waiting for iStart; oOut holds the last committed set
// ISSUE | feeding one snapshotted channel per cycle into the multiplier
// DRAIN | letting the pipeline empty, then committing the shadow bank
module mdac_shared
    import icesid_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int A_WIDTH   = 12,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iStart,
    input  logic [CHANNELS*A_WIDTH-1:0]   iA,
    input  logic [CHANNELS*B_WIDTH-1:0]   iB,
    output logic [CHANNELS*OUT_WIDTH-1:0] oOut,
    output logic                          oBusy,
    output logic                          oDone
);

    localparam int PW = A_WIDTH + B_WIDTH + 1;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

`ifdef MDAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    mdac_state_t state_q, state_d;
    logic        snap;
    logic        issue;
    logic        commit;

    logic [IW-1:0] idx_q;
    logic [1:0]    drain_cnt_q;

    logic signed [A_WIDTH-1:0]   bank_a [CHANNELS];
    logic        [B_WIDTH-1:0]   bank_b [CHANNELS];
    logic signed [OUT_WIDTH-1:0] shadow [CHANNELS];

    logic signed [A_WIDTH-1:0] op_a;
    logic        [B_WIDTH-1:0] op_b;
    logic                      op_v;
    logic        [IW-1:0]      op_k;

    logic signed [PW-1:0] prod;
    logic                 prod_v;
    logic [IW-1:0]        prod_k;

    logic signed [63:0] prod_w;
    logic signed [63:0] scaled;
    logic signed [63:0] red;
    logic               unused_hi;

    // The commit edge doubles as the next start edge, so a held iStart
    // gives back-to-back sweeps with no idle cycle in between.
    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        issue   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    snap    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (idx_q == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 2'd0) begin
                    commit = 1'b1;
                    if (iStart) begin
                        snap    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_w    = {{(64-PW){prod[PW-1]}}, prod};
        scaled    = prod_w >>> SHIFT;
        red       = mdac_reduce(scaled, OUT_WIDTH, SAT);
        unused_hi = ^red[63:OUT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_v        <= 1'b0;
            op_k        <= '0;
            prod_v      <= 1'b0;
            prod_k      <= '0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oOut        <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                bank_a[k] <= '0;
                bank_b[k] <= '0;
                shadow[k] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (snap) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    bank_a[k] <= iA[k*A_WIDTH +: A_WIDTH];
                    bank_b[k] <= iB[k*B_WIDTH +: B_WIDTH];
                end
                idx_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + 1'b1;
            end

            if (issue && (idx_q == LAST)) begin
                drain_cnt_q <= 2'(MDAC_PIPE_DEPTH - 1);
            end else if ((state_q == DRAIN) && (drain_cnt_q != 2'd0)) begin
                drain_cnt_q <= drain_cnt_q - 2'd1;
            end

            op_v <= issue;
            if (issue) begin
                op_a <= bank_a[idx_q];
                op_b <= bank_b[idx_q];
                op_k <= idx_q;
            end

            prod_v <= op_v;
            prod_k <= op_k;

            if (prod_v) begin
                shadow[prod_k] <= red[OUT_WIDTH-1:0];
            end

            if (snap) begin
                oBusy <= 1'b1;
            end else if (commit) begin
                oBusy <= 1'b0;
            end

            oDone <= commit;
            if (commit) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    oOut[k*OUT_WIDTH +: OUT_WIDTH] <= shadow[k];
                end
            end
        end
    end

    mdac_mul #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .a   (op_a),
        .b   (op_b),
        .p   (prod)
    );

endmodule

// File: tb/tb_mdac_shared.sv
// Scoreboard bench for mdac_shared: three instances (default, unshifted 2-channel,
// 16x16 single channel); expected results are hand-computed directed vectors.
module tb_mdac_shared;

    typedef struct {
        logic [47:0] out;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [47:0] committed0 = '0;

    logic        iStart0 = 1'b0;
    logic [35:0] iA0 = '0;
    logic [23:0] iB0 = '0;
    logic [47:0] oOut0;
    logic        oBusy0, oDone0;

    logic        iStart1 = 1'b0;
    logic [23:0] iA1 = '0;
    logic [15:0] iB1 = '0;
    logic [31:0] oOut1;
    logic        oBusy1, oDone1;

    logic        iStart2 = 1'b0;
    logic [15:0] iA2 = '0;
    logic [15:0] iB2 = '0;
    logic [15:0] oOut2;
    logic        oBusy2, oDone2;

    mdac_shared u_dut0 (
        .clk(clk), .rst(rst), .iStart(iStart0), .iA(iA0), .iB(iB0),
        .oOut(oOut0), .oBusy(oBusy0), .oDone(oDone0)
    );

    mdac_shared #(.CHANNELS(2), .A_WIDTH(12), .B_WIDTH(8), .OUT_WIDTH(16), .SHIFT(0)) u_dut1 (
        .clk(clk), .rst(rst), .iStart(iStart1), .iA(iA1), .iB(iB1),
        .oOut(oOut1), .oBusy(oBusy1), .oDone(oDone1)
    );

    mdac_shared #(.CHANNELS(1), .A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16), .SHIFT(16)) u_dut2 (
        .clk(clk), .rst(rst), .iStart(iStart2), .iA(iA2), .iB(iB2),
        .oOut(oOut2), .oBusy(oBusy2), .oDone(oDone2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] pa3(input int x0, input int x1, input int x2);
        return {12'(x2), 12'(x1), 12'(x0)};
    endfunction

    function automatic logic [23:0] pb3(input int x0, input int x1, input int x2);
        return {8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic [47:0] po3(input int x0, input int x1, input int x2);
        return {16'(x2), 16'(x1), 16'(x0)};
    endfunction

    // Called just after a rising edge; returns one cycle after the start edge E0.
    task automatic start0(input logic [35:0] a, input logic [23:0] b, input logic [47:0] exp);
        iStart0 = 1'b1;
        iA0 = a;
        iB0 = b;
        @(posedge clk); #1;
        iStart0 = 1'b0;
        q0.push_back('{out: exp, cyc: cyc + 6});
    endtask

    task automatic start2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        iStart2 = 1'b1;
        iA2 = a;
        iB2 = b;
        @(posedge clk); #1;
        iStart2 = 1'b0;
        q2.push_back('{out: 48'(exp), cyc: cyc + 4});
        repeat (6) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst) begin
            q0.delete();
            committed0 = '0;
        end else if (oDone0) begin
            chk("d0_done_expected", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0_out", 64'(oOut0), 64'(e.out));
                chk("d0_done_cycle", 64'(cyc), 64'(e.cyc));
                committed0 = e.out;
            end
        end else begin
            chk("d0_out_held", 64'(oOut0), 64'(committed0));
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            q1.delete();
        end else if (oDone1) begin
            chk("d1_done_expected", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1_out", 64'(oOut1), 64'(e.out));
                chk("d1_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst) begin
            q2.delete();
        end else if (oDone2) begin
            chk("d2_done_expected", 64'(q2.size() > 0), 64'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("d2_out", 64'(oOut2), 64'(e.out));
                chk("d2_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("d0_rst_out", 64'(oOut0), 64'd0);
        chk("d0_rst_busy", 64'(oBusy0), 64'd0);
        chk("d0_rst_done", 64'(oDone0), 64'd0);
        chk("d1_rst_out", 64'(oOut1), 64'd0);
        chk("d2_rst_out", 64'(oOut2), 64'd0);

        // Basic sweep with busy/done timing.
        start0(pa3(-2048, 1024, 0), pb3(255, 128, 77), po3(-32640, 8192, 0));
        chk("d0_busy_e0", 64'(oBusy0), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("d0_busy_sweep", 64'(oBusy0), 64'd1);
        end
        @(posedge clk); #1;
        chk("d0_busy_after_commit", 64'(oBusy0), 64'd0);
        chk("d0_done_pulse", 64'(oDone0), 64'd1);
        @(posedge clk); #1;
        chk("d0_done_one_cycle", 64'(oDone0), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Input change at E1 and a start re-pulse at E2 must be ignored.
        start0(pa3(100, -100, 2047), pb3(16, 3, 1), po3(100, -19, 127));
        iA0 = pa3(1, 1, 1);
        iB0 = pb3(0, 0, 0);
        @(posedge clk); #1;
        iStart0 = 1'b1;
        @(posedge clk); #1;
        iStart0 = 1'b0;
        chk("d0_busy_ignored_start", 64'(oBusy0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("d0_busy_end_ignored", 64'(oBusy0), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Held start: one sweep every 6 cycles, each using its own start-edge inputs.
        iStart0 = 1'b1;
        iA0 = pa3(-1, 1, -16);
        iB0 = pb3(1, 15, 255);
        @(posedge clk); #1;
        q0.push_back('{out: po3(-1, 0, -255), cyc: cyc + 6});
        iA0 = pa3(2047, -2048, 5);
        iB0 = pb3(255, 255, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("d0_busy_back_to_back", 64'(oBusy0), 64'd1);
        q0.push_back('{out: po3(32624, -32640, 0), cyc: cyc + 6});
        iA0 = pa3(-2048, 1024, 0);
        iB0 = pb3(255, 128, 77);
        repeat (6) @(posedge clk);
        #1;
        q0.push_back('{out: po3(-32640, 8192, 0), cyc: cyc + 6});
        iStart0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset at E3 aborts the sweep; a fresh start then completes normally.
        start0(pa3(100, -100, 2047), pb3(16, 3, 1), po3(100, -19, 127));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("d0_abort_out", 64'(oOut0), 64'd0);
        chk("d0_abort_busy", 64'(oBusy0), 64'd0);
        chk("d0_abort_done", 64'(oDone0), 64'd0);
        start0(pa3(2047, -2048, 5), pb3(255, 255, 0), po3(32624, -32640, 0));
        repeat (8) @(posedge clk);
        #1;

        // Unshifted overflow: 2047*255 and -2048*255 in a 16-bit result.
        iStart1 = 1'b1;
        iA1 = {12'h800, 12'h7FF};
        iB1 = {8'hFF, 8'hFF};
        @(posedge clk); #1;
        iStart1 = 1'b0;
`ifdef MDAC_SATURATE_EN
        q1.push_back('{out: 48'({16'h8000, 16'h7FFF}), cyc: cyc + 5});
`else
        q1.push_back('{out: 48'({16'h0800, 16'hF701}), cyc: cyc + 5});
`endif
        repeat (7) @(posedge clk);
        #1;

        // Full-width 16x16 single channel with SHIFT=16.
        start2(16'hFFFF, 16'hFFFF, 16'hFFFF);
        start2(16'h7FFF, 16'hFFFF, 16'h7FFE);
        start2(16'h8000, 16'hFFFF, 16'h8000);

        repeat (4) @(posedge clk);
        #1;
        chk("d0_all_sweeps_seen", 64'(q0.size()), 64'd0);
        chk("d1_all_sweeps_seen", 64'(q1.size()), 64'd0);
        chk("d2_all_sweeps_seen", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
